// File: rtl/bram_sdp_clear_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and helpers for the bram_sdp_clear block.
//               - rdw_mode_e    : read-during-write collision policy
//               - clear_state_e : clear engine FSM states
//               - addr_w()      : address width, never narrower than 1 bit
// Revision    : 1.0  initial release
// ============================================================================
package bram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

  // $clog2(1) is 0, which would give a zero-width address bus.
  function automatic int addr_w(input int depth);
    if (depth <= 1) return 1;
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdp_clear_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp_clear_if
// Description : Write port, read port and clear-control bundle of the RAM.
//               master : drives wr_*/rd_en/rd_addr/clear_start
//               slave  : drives wr_ready/rd_data/rd_valid/clear_busy/done
// Revision    : 1.0  initial release
// ============================================================================
interface bram_sdp_clear_if
  import bram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int BYTE_W = 8
);
  localparam int AW     = addr_w(DEPTH);
  localparam int NBYTES = WIDTH / BYTE_W;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NBYTES-1:0] wr_be;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clear_start,
    input  wr_ready, rd_data, rd_valid, clear_busy, clear_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clear_start,
    output wr_ready, rd_data, rd_valid, clear_busy, clear_done
  );
endinterface
`default_nettype wire

// File: rtl/bram_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_clear_ctrl
// Description : Clear engine. Sweeps addresses 0..DEPTH-1, one per cycle,
//               then pulses done for one cycle.
//   clk, rst    : clock, async active-high reset
//   clear_start : start request (ignored unless idle)
//   clr_we      : sweep write strobe;  clr_addr : sweep write address
//   busy        : sweep in progress;   done : one-cycle completion pulse
//   idle        : FSM in IDLE (external writes allowed)
// Revision    : 1.0  initial release
// ============================================================================
module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_start,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy,
  output logic          done,
  output logic          idle
);
  // Explicit terminal compare: DEPTH need not be a power of two.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clear_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = DONE;
        else                    cnt_d   = cnt_q + AW'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_addr = cnt_q;
  assign idle     = (state_q == IDLE);

endmodule
`default_nettype wire

// File: rtl/bram_sdp_clear.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp_clear
// Description : Single-clock simple-dual-port RAM with byte enables,
//               1- or 2-cycle read latency, selectable read-during-write
//               policy and a built-in one-word-per-cycle clear engine.
//   clk, rst : clock, async active-high reset
//   bus      : bram_sdp_clear_if slave (write, read and clear signals)
// Revision    : 1.0  initial release
// ============================================================================
module bram_sdp_clear
  import bram_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 1024,
  parameter int               BYTE_W       = 8,
  parameter int               READ_LATENCY = 1,
  parameter rdw_mode_e        RDW_MODE     = RDW_READ_FIRST,
  parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0,
  parameter string            FILE         = ""
) (
  input  logic            clk,
  input  logic            rst,
  bram_sdp_clear_if.slave bus
);
  localparam int AW     = addr_w(DEPTH);
  localparam int NBYTES = WIDTH / BYTE_W;

  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("bram_sdp_clear: WIDTH must be a multiple of BYTE_W");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Clear engine
  logic          clr_we, clr_busy, clr_done, clr_idle;
  logic [AW-1:0] clr_addr;

  bram_clear_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_clear_ctrl (
    .clk         (clk),
    .rst         (rst),
    .clear_start (bus.clear_start),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .busy        (clr_busy),
    .done        (clr_done),
    .idle        (clr_idle)
  );

  assign bus.wr_ready   = clr_idle;
  assign bus.clear_busy = clr_busy;
  assign bus.clear_done = clr_done;

  // Write-port mux. The sweep and external writes never overlap because
  // wr_ready is only high in IDLE; the sweep still takes priority.
  logic              we;
  logic [AW-1:0]     waddr;
  logic [NBYTES-1:0] wbe;
  logic [WIDTH-1:0]  wdata;

  always_comb begin
    we    = bus.wr_en && bus.wr_ready && (32'(bus.wr_addr) < 32'(DEPTH));
    waddr = bus.wr_addr;
    wbe   = bus.wr_be;
    wdata = bus.wr_data;
    if (clr_we) begin
      we    = 1'b1;
      waddr = clr_addr;
      wbe   = '1;
      wdata = CLEAR_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word with collision handling. In write-first mode the enabled
  // lanes of a same-address write bypass the array.
  logic [WIDTH-1:0] rd_old, rd_word;

  always_comb begin
    rd_old = '0;
    if (32'(bus.rd_addr) < 32'(DEPTH)) rd_old = mem[bus.rd_addr];
    rd_word = rd_old;
    if (RDW_MODE == RDW_WRITE_FIRST && we && waddr == bus.rd_addr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) rd_word[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage 1: loads on rd_en, holds otherwise.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  always_comb begin
    s1_valid_d = bus.rd_en;
    s1_data_d  = bus.rd_en ? rd_word : s1_data_q;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    // Output register loads only when stage 1 carries a result.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    assign bus.rd_valid = s2_valid_q;
    assign bus.rd_data  = s2_data_q;
  end else begin : g_lat1
    if (READ_LATENCY != 1) begin : g_bad_lat
      $error("bram_sdp_clear: READ_LATENCY must be 1 or 2");
    end
    assign bus.rd_valid = s1_valid_q;
    assign bus.rd_data  = s1_data_q;
  end

endmodule
`default_nettype wire
